// File: rtl/day07_pkg.sv
// Shared constants and FSM encoding for the day07 beam-splitting engine.
package day07_pkg;

   localparam logic [7:0] CH_S   = 8'h53;
   localparam logic [7:0] CH_DOT = 8'h2E;
   localparam logic [7:0] CH_SPL = 8'h5E;
   localparam logic [7:0] CH_NL  = 8'h0A;

   typedef enum logic [2:0] {
      FIRST_ROW,
      ROW,
      FLUSH,
      SUM,
      DONE,
      ERROR
   } state_e;

endpackage

// File: rtl/day07_sat_add.sv
// Unsigned adder that clamps to all-ones and flags when it had to clamp.
module day07_sat_add #(
   parameter int W = 64
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         ovf_o
);

   logic [W:0] full;

   assign full  = {1'b0, a_i} + {1'b0, b_i};
   assign ovf_o = full[W];
   assign sum_o = full[W] ? '1 : full[W-1:0];

endmodule

// File: rtl/day07_beam_engine.sv
// Streams a beam grid byte by byte, updating per-column timeline counts in place,
// then sums the final row. Handshake: a byte moves on a rising edge where in_valid_i && in_ready_o.
module day07_beam_engine
   import day07_pkg::*;
#(
   parameter int MAX_WIDTH = 256,
   parameter int CNT_WIDTH = 64,
   parameter int RES_WIDTH = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [7:0]           in_data_i,
   input  logic                 in_last_i,
   output logic [RES_WIDTH-1:0] part1_o,
   output logic [RES_WIDTH-1:0] part2_o,
   output logic                 done_o,
   output logic                 error_o,
   output logic                 overflow_o,
   output state_e               state_o
);

   localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam int CW = $clog2(MAX_WIDTH + 1);

   state_e               state_q, state_d;
   logic [CW-1:0]        col_q, col_d, width_q, width_d, col_plus;
   logic                 s_seen_q, s_seen_d, last_q, last_d;
   logic [CNT_WIDTH-1:0] old_m1_q, old_m1_d, old_m2_q, old_m2_d;
   logic                 spl_m1_q, spl_m1_d, spl_m2_q, spl_m2_d;
   logic [RES_WIDTH-1:0] part1_q, part1_d, part2_q, part2_d;
   logic                 ovf_q, ovf_d, in_ready_q, done_q, error_q;

   logic [CNT_WIDTH-1:0] cnt_q [MAX_WIDTH];
   logic                 wr_en;
   logic [AW-1:0]        wr_idx;
   logic [CNT_WIDTH-1:0] wr_data;

   logic                 accept, is_spl, is_cell;
   logic [CNT_WIDTH-1:0] cur_k, term_a, term_b, term_c, sum_ab, nxt_cnt;
   logic [RES_WIDTH-1:0] p1_inc, p2_sum;
   logic                 ovf_ab, ovf_c, ovf_p1, ovf_p2;

   assign accept   = in_valid_i & in_ready_q;
   assign is_spl   = (in_data_i == CH_SPL);
   assign is_cell  = (in_data_i == CH_DOT) | is_spl;
   assign col_plus = col_q + CW'(1);
   assign cur_k    = cnt_q[col_q[AW-1:0]];

   // next[k-1] from the two saved old counts (k-1, k-2) and the still-unwritten cur[k]
   assign term_a = spl_m1_q ? '0 : old_m1_q;
   assign term_b = spl_m2_q ? old_m2_q : '0;
   assign term_c = (state_q == ROW && is_spl) ? cur_k : '0;

   day07_sat_add #(.W(CNT_WIDTH)) u_add_ab (.a_i(term_a), .b_i(term_b), .sum_o(sum_ab), .ovf_o(ovf_ab));
   day07_sat_add #(.W(CNT_WIDTH)) u_add_c  (.a_i(sum_ab), .b_i(term_c), .sum_o(nxt_cnt), .ovf_o(ovf_c));
   day07_sat_add #(.W(RES_WIDTH)) u_add_p1 (.a_i(part1_q), .b_i(RES_WIDTH'(1)), .sum_o(p1_inc), .ovf_o(ovf_p1));
   day07_sat_add #(.W(RES_WIDTH)) u_add_p2 (.a_i(part2_q), .b_i(RES_WIDTH'(cur_k)), .sum_o(p2_sum), .ovf_o(ovf_p2));

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      width_d  = width_q;
      s_seen_d = s_seen_q;
      last_d   = last_q;
      old_m1_d = old_m1_q;
      old_m2_d = old_m2_q;
      spl_m1_d = spl_m1_q;
      spl_m2_d = spl_m2_q;
      part1_d  = part1_q;
      part2_d  = part2_q;
      ovf_d    = ovf_q;
      wr_en    = 1'b0;
      wr_idx   = AW'(col_q - CW'(1));
      wr_data  = nxt_cnt;
      case (state_q)
         FIRST_ROW: if (accept) begin
            if (in_last_i) begin
               state_d = ERROR;
            end else if (in_data_i == CH_NL) begin
               if (!s_seen_q) state_d = ERROR;
               else begin
                  width_d = col_q;
                  col_d   = '0;
                  state_d = ROW;
               end
            end else if (in_data_i == CH_DOT || in_data_i == CH_S) begin
               if (col_q == CW'(MAX_WIDTH) || (in_data_i == CH_S && s_seen_q)) state_d = ERROR;
               else begin
                  wr_en    = 1'b1;
                  wr_idx   = col_q[AW-1:0];
                  wr_data  = (in_data_i == CH_S) ? CNT_WIDTH'(1) : '0;
                  col_d    = col_plus;
                  s_seen_d = s_seen_q | (in_data_i == CH_S);
               end
            end else begin
               state_d = ERROR;
            end
         end
         ROW: if (accept) begin
            if (in_data_i == CH_NL) begin
               if (col_q == '0) begin
                  if (in_last_i) state_d = SUM;
               end else if (col_q != width_q) begin
                  state_d = ERROR;
               end else begin
                  state_d = FLUSH;
                  last_d  = in_last_i;
               end
            end else if (is_cell) begin
               if (col_q == width_q || (in_last_i && col_plus != width_q)) state_d = ERROR;
               else begin
                  wr_en    = (col_q != '0);
                  ovf_d    = ovf_q | ((col_q != '0) & (ovf_ab | ovf_c));
                  old_m1_d = cur_k;
                  old_m2_d = old_m1_q;
                  spl_m1_d = is_spl;
                  spl_m2_d = spl_m1_q;
                  if (is_spl && cur_k != '0) begin
                     part1_d = p1_inc;
                     ovf_d   = ovf_d | ovf_p1;
                  end
                  col_d = col_plus;
                  if (in_last_i) begin
                     state_d = FLUSH;
                     last_d  = 1'b1;
                  end
               end
            end else begin
               state_d = ERROR;
            end
         end
         FLUSH: begin
            wr_en    = 1'b1;
            wr_idx   = AW'(width_q - CW'(1));
            ovf_d    = ovf_q | ovf_ab | ovf_c;
            old_m1_d = '0;
            old_m2_d = '0;
            spl_m1_d = 1'b0;
            spl_m2_d = 1'b0;
            col_d    = '0;
            state_d  = last_q ? SUM : ROW;
         end
         SUM: begin
            part2_d = p2_sum;
            ovf_d   = ovf_q | ovf_p2;
            col_d   = col_plus;
            if (col_plus == width_q) state_d = DONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= FIRST_ROW;
         col_q      <= '0;
         width_q    <= '0;
         s_seen_q   <= 1'b0;
         last_q     <= 1'b0;
         old_m1_q   <= '0;
         old_m2_q   <= '0;
         spl_m1_q   <= 1'b0;
         spl_m2_q   <= 1'b0;
         part1_q    <= '0;
         part2_q    <= '0;
         ovf_q      <= 1'b0;
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         width_q    <= width_d;
         s_seen_q   <= s_seen_d;
         last_q     <= last_d;
         old_m1_q   <= old_m1_d;
         old_m2_q   <= old_m2_d;
         spl_m1_q   <= spl_m1_d;
         spl_m2_q   <= spl_m2_d;
         part1_q    <= part1_d;
         part2_q    <= part2_d;
         ovf_q      <= ovf_d;
         in_ready_q <= (state_d == FIRST_ROW) || (state_d == ROW);
         done_q     <= (state_d == DONE) || (state_d == ERROR);
         error_q    <= (state_d == ERROR);
      end
   end

   // Stale entries are harmless: every column below the latched width is rewritten by the first row.
   always_ff @(posedge clk_i) begin
      if (wr_en) cnt_q[wr_idx] <= wr_data;
   end

   assign in_ready_o = in_ready_q;
   assign part1_o    = part1_q;
   assign part2_o    = part2_q;
   assign done_o     = done_q;
   assign error_o    = error_q;
   assign overflow_o = ovf_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_day07_beam_engine.sv
// Bench for day07_beam_engine: a 64-bit and a 4-bit-counter instance share one input stream.
module tb_day07_beam_engine;
   import day07_pkg::*;

   localparam int RW = 64;
   localparam int EW = 2 + 2 * RW;

   logic          clk_i = 1'b0;
   logic          rst_ni, in_valid_i, in_last_i;
   logic [7:0]    in_data_i;
   logic          a_ready, a_done, a_err, a_ovf, b_ready, b_done, b_err, b_ovf;
   logic [RW-1:0] a_p1, a_p2, b_p1, b_p2;
   state_e        a_state, b_state;

   int            n_vec = 0;
   int            n_bad = 0;
   logic [EW-1:0] exp_q[$];
   bit            m_ovf;

   always #5 clk_i = ~clk_i;

   day07_beam_engine u_dut_a (
      .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(a_ready),
      .in_data_i(in_data_i), .in_last_i(in_last_i), .part1_o(a_p1), .part2_o(a_p2),
      .done_o(a_done), .error_o(a_err), .overflow_o(a_ovf), .state_o(a_state)
   );

   day07_beam_engine #(.CNT_WIDTH(4)) u_dut_b (
      .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(b_ready),
      .in_data_i(in_data_i), .in_last_i(in_last_i), .part1_o(b_p1), .part2_o(b_p2),
      .done_o(b_done), .error_o(b_err), .overflow_o(b_ovf), .state_o(b_state)
   );

   task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input bit err, input bit ovf, input longint unsigned p1, input longint unsigned p2);
      return {err, ovf, p1, p2};
   endfunction

   function automatic longint unsigned sadd(input longint unsigned a, input longint unsigned b, input longint unsigned lim);
      if (a > lim - b) begin
         m_ovf = 1'b1;
         return lim;
      end
      return a + b;
   endfunction

   // Whole-row reference: each beam either passes straight down or splits to both neighbours.
   function automatic logic [EW-1:0] model(input string s, input int bits);
      longint unsigned lim, c, p1, p2;
      longint unsigned cur[16], nxt[16];
      bit first;
      int w;
      string r;
      lim = (bits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
      m_ovf = 1'b0; first = 1'b1; p1 = 0; p2 = 0; w = 0; r = "";
      for (int j = 0; j < 16; j++) cur[j] = 0;
      for (int i = 0; i <= s.len(); i++) begin
         if (i == s.len() || s[i] == CH_NL) begin
            if (r.len() > 0) begin
               if (first) begin
                  w = r.len();
                  for (int j = 0; j < w; j++) cur[j] = (r[j] == CH_S) ? 1 : 0;
                  first = 1'b0;
               end else begin
                  for (int j = 0; j < w; j++) nxt[j] = 0;
                  for (int j = 0; j < w; j++) begin
                     c = cur[j];
                     if (r[j] == CH_SPL) begin
                        if (c > 0) p1++;
                        if (j > 0) nxt[j-1] = sadd(nxt[j-1], c, lim);
                        if (j < w - 1) nxt[j+1] = sadd(nxt[j+1], c, lim);
                     end else begin
                        nxt[j] = sadd(nxt[j], c, lim);
                     end
                  end
                  for (int j = 0; j < w; j++) cur[j] = nxt[j];
               end
            end
            r = "";
         end else begin
            r = $sformatf("%s%c", r, s[i]);
         end
      end
      for (int j = 0; j < w; j++) p2 = sadd(p2, cur[j], 64'hFFFF_FFFF_FFFF_FFFF);
      return mk(1'b0, m_ovf, p1, p2);
   endfunction

   task automatic do_reset(input int cycles);
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      in_data_i  = 8'h00;
      rst_ni     = 1'b0;
      repeat (cycles) @(negedge clk_i);
      check_val("rst.p1", a_p1, 0);
      check_val("rst.p2", a_p2, 0);
      check_val("rst.done", a_done, 0);
      check_val("rst.err", a_err, 0);
      check_val("rst.ovf", a_ovf, 0);
      check_val("rst.ready", a_ready, 0);
      check_val("rst.state", a_state, FIRST_ROW);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_val("rst.ready_after", a_ready, 1);
   endtask

   task automatic put_byte(input logic [7:0] b, input bit last, input bit gaps, output bit ok);
      int n;
      ok = 1'b1;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk_i);
      in_valid_i = 1'b1;
      in_data_i  = b;
      in_last_i  = last;
      n = 0;
      while (!a_ready && !a_done && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (a_ready) @(negedge clk_i);
      else ok = 1'b0;
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
   endtask

   task automatic send_stream(input string s, input bit gaps, input bit with_last, output int lat);
      bit ok;
      lat = 0;
      for (int i = 0; i < s.len(); i++) begin
         put_byte(s[i], with_last && (i == s.len() - 1), gaps, ok);
         if (!ok) begin
            if (!a_done) check_val("ready_timeout", a_ready, 1);
            break;
         end
      end
      if (with_last) begin
         while (!a_done && lat < 600) begin
            @(negedge clk_i);
            lat++;
         end
         if (!a_done) check_val("done_timeout", a_done, 1);
      end
   endtask

   task automatic score(input string name, input int w, input int lat);
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check_val({name, ".a.p1"}, a_p1, e[127:64]);
      check_val({name, ".a.p2"}, a_p2, e[63:0]);
      check_val({name, ".a.err"}, a_err, RW'(e[129]));
      check_val({name, ".a.ovf"}, a_ovf, RW'(e[128]));
      check_val({name, ".a.done"}, a_done, 1);
      check_val({name, ".a.state"}, a_state, e[129] ? RW'(ERROR) : RW'(DONE));
      if (!e[129]) check_val({name, ".a.latency"}, (lat <= w + 3) ? 0 : lat, 0);
      e = exp_q.pop_front();
      check_val({name, ".b.p1"}, b_p1, e[127:64]);
      check_val({name, ".b.p2"}, b_p2, e[63:0]);
      check_val({name, ".b.err"}, b_err, RW'(e[129]));
      check_val({name, ".b.ovf"}, b_ovf, RW'(e[128]));
   endtask

   task automatic run_case(input string name, input string s, input bit gaps, input bit rst,
                           input int w, input logic [EW-1:0] ea, input logic [EW-1:0] eb);
      int lat;
      if (rst) do_reset(2);
      exp_q.push_back(ea);
      exp_q.push_back(eb);
      send_stream(s, gaps, 1'b1, lat);
      score(name, w, lat);
   endtask

   task automatic gen_grid(output string s, output int w);
      int rows, scol;
      w    = $urandom_range(1, 10);
      rows = $urandom_range(1, 7);
      scol = $urandom_range(0, w - 1);
      s = "";
      for (int j = 0; j < w; j++) s = $sformatf("%s%c", s, (j == scol) ? CH_S : CH_DOT);
      s = $sformatf("%s%c", s, CH_NL);
      for (int r = 0; r < rows; r++) begin
         if ($urandom_range(0, 4) == 0) s = $sformatf("%s%c", s, CH_NL);
         for (int j = 0; j < w; j++)
            s = $sformatf("%s%c", s, ($urandom_range(0, 2) == 0) ? CH_SPL : CH_DOT);
         if (r < rows - 1 || $urandom_range(0, 1) == 0) s = $sformatf("%s%c", s, CH_NL);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      string s, rep;
      int    w, lat;
      rst_ni     = 1'b0;
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      in_data_i  = 8'h00;

      run_case("basic", "..S..\n.....\n..^..\n", 1'b0, 1'b1, 5, mk(0, 0, 1, 2), mk(0, 0, 1, 2));
      run_case("edges", ".S.\n.^.\n^.^\n", 1'b0, 1'b1, 3, mk(0, 0, 3, 2), mk(0, 0, 3, 2));

      rep = ".S.\n";
      for (int i = 0; i < 4; i++) rep = {rep, ".^.\n^.^\n"};
      run_case("saturate", rep, 1'b0, 1'b1, 3, mk(0, 0, 12, 16), mk(0, 1, 12, 15));

      run_case("two_s", "S.S\n", 1'b0, 1'b1, 3, mk(1, 0, 0, 0), mk(1, 0, 0, 0));
      run_case("width_mismatch", "..S\n..\n", 1'b0, 1'b1, 3, mk(1, 0, 0, 0), mk(1, 0, 0, 0));
      run_case("last_in_first", "..S", 1'b0, 1'b1, 3, mk(1, 0, 0, 0), mk(1, 0, 0, 0));
      run_case("illegal_byte", ".S.\n.x.\n", 1'b0, 1'b1, 3, mk(1, 0, 0, 0), mk(1, 0, 0, 0));
      run_case("blank_gaps", ".S.\n\n\n.^.\n...", 1'b1, 1'b1, 3, mk(0, 0, 1, 2), mk(0, 0, 1, 2));

      // Progress from an abandoned stream must not leak into the next one.
      do_reset(2);
      send_stream("..S..\n.^^", 1'b0, 1'b0, lat);
      do_reset(1);
      run_case("after_reset", "..S..\n.....\n..^..\n", 1'b0, 1'b0, 5, mk(0, 0, 1, 2), mk(0, 0, 1, 2));

      for (int g = 0; g < 8; g++) begin
         gen_grid(s, w);
         run_case($sformatf("rand%0d", g), s, 1'b1, 1'b1, w, model(s, 64), model(s, 4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
